cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Bridges the L2 cache's single-transfer 256-bit line port to the 64-bit, 4-beat burst physical-memory port at the mp4 top level (pmem_read/write/address/wdata/rdata/resp).
- Sits directly downstream of the L2 cache and directly upstream of burst memory.
- Buffers one full line; serialises writebacks into beats and assembles read beats into a line.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, width of one memory beat.
- BURST_LEN (derived localparam), LINE_WIDTH/BURST_WIDTH = 4, beats per line.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- line_read  in  1  L2 requests a line fill.
- line_write  in  1  L2 requests a line writeback.
- line_address  in  32  line address; low 5 bits ignored.
- line_wdata  in  256  writeback line.
- line_rdata  out  256  filled line.
- line_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  32  line-aligned burst address.
- pmem_wdata  out  64  current write beat.
- pmem_rdata  in  64  current read beat.
- pmem_resp  in  1  beat accepted/valid.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, beat counter 0, line buffer 0, address register 0. All outputs 0 immediately, including pmem_read/pmem_write during an active burst.
- States: IDLE, READ_BURST, WRITE_BURST, DONE.
- IDLE:
  - line_read=1: latch {line_address[31:5],5'b0}, clear counter, go to READ_BURST.
  - line_write=1 (and line_read=0): also latch line_wdata into the buffer, go to WRITE_BURST.
  - Both high: read wins; write is ignored that cycle.
  - pmem_resp is ignored.
- READ_BURST:
  - pmem_read=1; pmem_address = latched address, stable for the whole burst.
  - Each cycle with pmem_resp=1: buffer[cnt*64 +: 64] <= pmem_rdata; cnt++.
  - Response on cnt=3 moves to DONE.
- WRITE_BURST:
  - pmem_write=1; pmem_wdata = buffer[cnt*64 +: 64], combinational from counter.
  - Each pmem_resp advances cnt; response on cnt=3 moves to DONE.
- Beat ordering: beat 0 is line bits [63:0], ascending.
- Gaps: cycles without pmem_resp hold the counter, data and requests unchanged. Non-consecutive beats are legal.
- DONE:
  - line_resp=1 for exactly one cycle; pmem_read/pmem_write=0.
  - line_rdata valid (after a read).
  - Unconditionally returns to IDLE; requests are not sampled in DONE.
- line_rdata = buffer register; holds its value until the next read burst or writeback overwrites the buffer. Valid only in the line_resp cycle.
- pmem_read, pmem_write and line_resp are decoded from state registers only, so they are glitch-free with no combinational path from inputs.
- Latency:
  - Request sampled at edge 0; pmem_read high cycle 1.
  - With back-to-back resp in cycles 1-4, DONE/line_resp in cycle 5.
  - Minimum 5 cycles request-to-resp; each resp-gap cycle adds one.
- L2 must drop line_read/line_write in the line_resp cycle. A request still high in the following IDLE cycle starts a new transaction.
- Counter is 2 bits and wraps 3→0 on the final beat; it is cleared again on the next entry from IDLE.

Decomposition:
- Shared package (cache_types_pkg): LINE_WIDTH, BURST_WIDTH, BURST_LEN, OFFSET_BITS=5, typedef line_t (256-bit), beat_t (64-bit), adaptor state enum.
- No sub-module; FSM, counter and buffer in one module.

Test Plan:
- Read, address 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp -> pmem_address=0x0000_1220 held; line_resp in cycle 5 only; line_rdata={0x44..,0x33..,0x22..,0x11..}.
- Write, line_wdata={0xDD..,0xCC..,0xBB..,0xAA..} -> pmem_wdata 0xAA..,0xBB..,0xCC..,0xDD.. on successive resps; pmem_write drops in DONE; one line_resp.
- Read with resp gaps (resp cycles 1,3,4,7) -> data assembled correctly; line_resp in cycle 8; pmem_read held high through cycle 7.
- rst low in cycle 2 of a read burst -> pmem_read=0 same cycle (asynchronous); no line_resp; after release a new read completes normally.
- line_read=line_write=1 in IDLE -> read burst issued, pmem_write never asserted.
- Stray pmem_resp while IDLE, and request held one cycle past line_resp -> IDLE ignores the stray resp; held request starts exactly one new transaction.

Source files
------------

// File: rtl/cache_types_pkg.sv
`default_nettype none
// cache_types_pkg: widths, line/beat types and adaptor state encoding shared by
// the cache-line adaptor and its interface.
package cache_types_pkg;

  localparam int LINE_WIDTH    = 256;
  localparam int BURST_WIDTH   = 64;
  localparam int BURST_LEN     = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS   = 5;
  localparam int CNT_BITS      = $clog2(BURST_LEN);
  localparam int BEAT_SHIFT    = $clog2(BURST_WIDTH);
  localparam int LINE_IDX_BITS = $clog2(LINE_WIDTH);

  localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [31:0]            addr_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_READ_BURST  = 2'd1,
    ST_WRITE_BURST = 2'd2,
    ST_DONE        = 2'd3
  } adaptor_state_e;

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor_if.sv
`default_nettype none
// cacheline_adaptor_if: L2 line port plus burst memory port; master is the
// adaptor, slave is the surrounding L2/memory environment.
interface cacheline_adaptor_if;
  import cache_types_pkg::*;

  logic  line_read;
  logic  line_write;
  addr_t line_address;
  line_t line_wdata;
  line_t line_rdata;
  logic  line_resp;

  logic  pmem_read;
  logic  pmem_write;
  addr_t pmem_address;
  beat_t pmem_wdata;
  beat_t pmem_rdata;
  logic  pmem_resp;

  modport master (
    input  line_read, line_write, line_address, line_wdata, pmem_rdata, pmem_resp,
    output line_rdata, line_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output line_read, line_write, line_address, line_wdata, pmem_rdata, pmem_resp,
    input  line_rdata, line_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// cacheline_adaptor: buffers one 256-bit cache line and moves it to/from burst
// memory as four 64-bit beats, beat 0 = line bits [63:0].
module cacheline_adaptor
  import cache_types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.master bus
);

  adaptor_state_e           state_q;
  logic [CNT_BITS-1:0]      cnt_q;
  line_t                    buf_q;
  addr_t                    addr_q;
  logic [LINE_IDX_BITS-1:0] beat_lsb;
  logic                     last_beat;

  assign beat_lsb  = {cnt_q, {BEAT_SHIFT{1'b0}}};
  assign last_beat = (cnt_q == CNT_BITS'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Read has priority when both requests arrive together.
          if (bus.line_read) begin
            addr_q  <= bus.line_address & LINE_ADDR_MASK;
            cnt_q   <= '0;
            state_q <= ST_READ_BURST;
          end else if (bus.line_write) begin
            addr_q  <= bus.line_address & LINE_ADDR_MASK;
            buf_q   <= bus.line_wdata;
            cnt_q   <= '0;
            state_q <= ST_WRITE_BURST;
          end
        end
        ST_READ_BURST: begin
          if (bus.pmem_resp) begin
            buf_q[beat_lsb +: BURST_WIDTH] <= bus.pmem_rdata;
            cnt_q                          <= cnt_q + 1'b1;
            if (last_beat) state_q <= ST_DONE;
          end
        end
        ST_WRITE_BURST: begin
          if (bus.pmem_resp) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request and completion strobes come straight from the state register.
  assign bus.pmem_read    = (state_q == ST_READ_BURST);
  assign bus.pmem_write   = (state_q == ST_WRITE_BURST);
  assign bus.line_resp    = (state_q == ST_DONE);
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = buf_q[beat_lsb +: BURST_WIDTH];
  assign bus.line_rdata   = buf_q;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// tb_cacheline_adaptor: drives L2 requests and burst-memory responses, and
// checks every cycle against a transaction-level expectation.
module tb_cacheline_adaptor;
  import cache_types_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One line transaction, entered and left at a negedge while the adaptor idles.
  task automatic transaction(input bit is_read, input bit also_write, input logic [31:0] addr,
                             input logic [15:0] pat, input bit fixed, input bit hold_after);
    beat_t       beats [BURST_LEN];
    line_t       lin;
    logic [31:0] exp_addr;
    int          got;
    int          cyc;
    bit          resp;
    exp_addr = {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    for (int i = 0; i < BURST_LEN; i++) begin
      if (fixed) beats[i] = is_read ? {16{4'(i + 1)}} : {8{8'(8'hAA + 17 * i)}};
      else       beats[i] = {$urandom, $urandom};
      lin[i*BURST_WIDTH +: BURST_WIDTH] = beats[i];
    end
    check("idle_rd", bus.pmem_read, 0);
    check("idle_wr", bus.pmem_write, 0);
    bus.line_address = addr;
    bus.line_read    = is_read;
    bus.line_write   = !is_read || also_write;
    bus.line_wdata   = is_read ? {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom} : lin;
    @(negedge clk);
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    got = 0;
    cyc = 0;
    while (got < BURST_LEN && cyc < 40) begin
      cyc++;
      check(is_read ? "rd_req" : "wr_req", is_read ? bus.pmem_read : bus.pmem_write, 1);
      check("other_req", is_read ? bus.pmem_write : bus.pmem_read, 0);
      check("addr", bus.pmem_address, exp_addr);
      check("early_resp", bus.line_resp, 0);
      if (!is_read) check("wdata", bus.pmem_wdata, beats[got]);
      resp = (pat != 16'd0) ? ((cyc <= 16) ? pat[cyc-1] : 1'b1) : ($urandom_range(0, 2) != 0);
      bus.pmem_resp  = resp;
      bus.pmem_rdata = (resp && is_read) ? beats[got] : {$urandom, $urandom};
      if (resp) got++;
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
    check("timeout", got, BURST_LEN);
    check("done_resp", bus.line_resp, 1);
    check("done_rd", bus.pmem_read, 0);
    check("done_wr", bus.pmem_write, 0);
    if (is_read) check("line", bus.line_rdata, lin);
    if (hold_after) begin
      bus.line_read = 1'b1;
    end else begin
      @(negedge clk);
      check("post_resp", bus.line_resp, 0);
    end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    rst              = 1'b0;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_address = '0;
    bus.line_wdata   = '0;
    bus.pmem_rdata   = '0;
    bus.pmem_resp    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd", bus.pmem_read, 0);
    check("rst_wr", bus.pmem_write, 0);
    check("rst_resp", bus.line_resp, 0);
    check("rst_addr", bus.pmem_address, 0);
    check("rst_line", bus.line_rdata, 0);
    check("rst_wdata", bus.pmem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Stray memory response while idle.
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("stray_rd", bus.pmem_read, 0);
    check("stray_wr", bus.pmem_write, 0);
    check("stray_resp", bus.line_resp, 0);

    transaction(1'b1, 1'b0, 32'h0000_1234, 16'h000F, 1'b1, 1'b0);
    transaction(1'b0, 1'b0, 32'h0000_2A5F, 16'h000F, 1'b1, 1'b0);
    transaction(1'b1, 1'b0, 32'h8000_0047, 16'h004D, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a read burst.
    bus.line_address = 32'h0000_4000;
    bus.line_read    = 1'b1;
    @(negedge clk);
    bus.line_read  = 1'b0;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("mid_rd", bus.pmem_read, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_rd", bus.pmem_read, 0);
    check("arst_addr", bus.pmem_address, 0);
    check("arst_line", bus.line_rdata, 0);
    check("arst_resp", bus.line_resp, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_resp", bus.line_resp, 0);
    transaction(1'b1, 1'b0, 32'h0000_4020, 16'd0, 1'b0, 1'b0);

    // Simultaneous read and write requests.
    transaction(1'b1, 1'b1, 32'h1234_5678, 16'd0, 1'b0, 1'b0);

    // Request held into the IDLE cycle after line_resp.
    transaction(1'b1, 1'b0, 32'h0000_6000, 16'h000F, 1'b0, 1'b1);
    @(negedge clk);
    transaction(1'b1, 1'b0, 32'h0000_7000, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("one_more_rd", bus.pmem_read, 0);
      @(negedge clk);
    end

    for (int i = 0; i < 12; i++) begin
      automatic bit rd = 1'($urandom_range(0, 1));
      transaction(rd, rd & 1'($urandom_range(0, 1)), $urandom, 16'd0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
`default_nettype wire
